// File: rtl/arb_pkg.sv
// arb_pkg: shared state, owner encoding and default widths for the memory arbiter
package arb_pkg;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/arb_req_buf.sv
// arb_req_buf: request buffer holding the granted payload and its owner until the next grant
module arb_req_buf
   import arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_wdata,
   input  logic [DATA_W/8-1:0] ld_wstrb,
   input  logic                ld_we,
   input  logic                ld_own,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                we,
   output logic                own
);
   // capture the payload on the grant cycle; it stays stable until the next grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr  <= '0;
         wdata <= '0;
         wstrb <= '0;
         we    <= 1'b0;
         own   <= OWN_INST;
      end else if (ld) begin
         addr  <= ld_addr;
         wdata <= ld_wdata;
         wstrb <= ld_wstrb;
         we    <= ld_we;
         own   <= ld_own;
      end
   end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serialises core fetch and load/store channels onto one memory port
module cpu_mem_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req_valid,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                inst_req_ready,
   output logic                inst_valid,
   output logic [DATA_W-1:0]   inst_data,
   input  logic                inst_ready,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_wstrb,
   output logic                mem_req_ready,
   output logic                rdata_valid,
   output logic [DATA_W-1:0]   rdata,
   input  logic                rdata_ready,
   output logic                m_req_valid,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   input  logic                m_req_ready,
   input  logic                m_rvalid,
   input  logic [DATA_W-1:0]   m_rdata,
   output logic                m_rready,
   output logic [31:0]         arb_conflict_cnt
);
   arb_state_t        state;
   logic [DATA_W-1:0] resp;
   logic              own;
   logic              idle;
   logic              data_req;
   logic              grant;
   logic              core_ready;

   assign idle           = state == IDLE;
   assign data_req       = mem_read | mem_write;
   assign grant          = idle & (data_req | inst_req_valid);
   assign mem_req_ready  = idle & data_req;
   assign inst_req_ready = idle & inst_req_valid & ~data_req;
   assign m_req_valid    = state == REQ;
   assign m_rready       = state == WAIT;
   assign inst_valid     = state == RESP && own == OWN_INST;
   assign rdata_valid    = state == RESP && own == OWN_DATA;
   assign inst_data      = resp;
   assign rdata          = resp;
   assign core_ready     = own == OWN_DATA ? rdata_ready : inst_ready;

   arb_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .ld       (grant),
      .ld_addr  (data_req ? mem_addr : inst_addr),
      .ld_wdata (data_req ? mem_wdata : '0),
      .ld_wstrb (data_req ? mem_wstrb : '0),
      .ld_we    (mem_write),
      .ld_own   (data_req ? OWN_DATA : OWN_INST),
      .addr     (m_addr),
      .wdata    (m_wdata),
      .wstrb    (m_wstrb),
      .we       (m_we),
      .own      (own)
   );

   // transaction sequencing and response capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         resp  <= '0;
      end else begin
         case (state)
            IDLE: state <= grant ? REQ : IDLE;
            REQ:  state <= !m_req_ready ? REQ : m_we ? IDLE : WAIT;
            WAIT: if (m_rvalid) begin
               resp  <= m_rdata;
               state <= RESP;
            end
            RESP: state <= core_ready ? IDLE : RESP;
            default: state <= IDLE;
         endcase
      end
   end

   // count idle cycles where both channels compete for the port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) arb_conflict_cnt <= '0;
      else if (idle && inst_req_valid && data_req) arb_conflict_cnt <= arb_conflict_cnt + 32'd1;
   end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed self-checking bench for the memory arbiter
module tb_cpu_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        inst_req_valid = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        inst_req_ready;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic        inst_ready = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_req_ready;
   logic        rdata_valid;
   logic [31:0] rdata;
   logic        rdata_ready = 1'b0;
   logic        m_req_valid;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_req_ready = 1'b0;
   logic        m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        m_rready;
   logic [31:0] arb_conflict_cnt;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   cpu_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req_valid(inst_req_valid), .inst_addr(inst_addr), .inst_req_ready(inst_req_ready),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_ready(inst_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
      .rdata_valid(rdata_valid), .rdata(rdata), .rdata_ready(rdata_ready),
      .m_req_valid(m_req_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_wstrb(m_wstrb), .m_req_ready(m_req_ready),
      .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
      .arb_conflict_cnt(arb_conflict_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_state_ready", {inst_req_ready, mem_req_ready, m_rready}, 0);
      check("rst_valids", {inst_valid, rdata_valid, m_req_valid, m_we}, 0);
      check("rst_payload", {m_addr, m_wdata[27:0], m_wstrb}, 0);
      check("rst_resp", rdata, 0);
      check("rst_cnt", arb_conflict_cnt, 0);
      rst = 1'b1;
      // single fetch
      inst_req_valid = 1'b1;
      inst_addr = 32'h100;
      #1;
      check("f_inst_ready", {inst_req_ready, mem_req_ready}, 2'b10);
      tick;
      inst_req_valid = 1'b0;
      check("f_req", {m_req_valid, m_we, inst_req_ready}, 3'b100);
      check("f_addr", m_addr, 32'h100);
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      check("f_wait", {m_rready, m_req_valid, inst_valid}, 3'b100);
      m_rvalid = 1'b1;
      m_rdata = 32'h00000013;
      tick;
      m_rvalid = 1'b0;
      check("f_resp", {inst_valid, rdata_valid, m_rready}, 3'b100);
      check("f_data", inst_data, 32'h00000013);
      inst_ready = 1'b1;
      tick;
      inst_ready = 1'b0;
      check("f_done", {inst_valid, m_req_valid}, 0);
      // store with delayed memory acceptance
      mem_write = 1'b1;
      mem_addr = 32'h2000;
      mem_wdata = 32'hDEADBEEF;
      mem_wstrb = 4'b0011;
      #1;
      check("s_ready", {mem_req_ready, inst_req_ready}, 2'b10);
      tick;
      mem_write = 1'b0;
      mem_addr = 32'h5555;
      mem_wdata = 32'h0;
      mem_wstrb = 4'hF;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) m_req_ready = 1'b1;
         #1;
         check($sformatf("s_hold%0d", i), {m_req_valid, m_we, m_addr, m_wdata, m_wstrb}, {2'b11, 32'h2000, 32'hDEADBEEF, 4'b0011});
         tick;
      end
      m_req_ready = 1'b0;
      check("s_done", {m_req_valid, rdata_valid, m_rready, mem_req_ready}, 0);
      tick;
      check("s_no_second", m_req_valid, 0);
      // simultaneous fetch and load
      inst_req_valid = 1'b1;
      inst_addr = 32'h40;
      mem_read = 1'b1;
      mem_addr = 32'h80;
      #1;
      check("c_grant", {mem_req_ready, inst_req_ready}, 2'b10);
      tick;
      mem_read = 1'b0;
      check("c_load_first", {m_req_valid, m_we, m_addr}, {2'b10, 32'h80});
      check("c_cnt", arb_conflict_cnt, 1);
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      m_rvalid = 1'b1;
      m_rdata = 32'hAAAA5555;
      tick;
      m_rvalid = 1'b0;
      check("c_load_resp", {rdata_valid, inst_valid, rdata}, {2'b10, 32'hAAAA5555});
      rdata_ready = 1'b1;
      tick;
      rdata_ready = 1'b0;
      check("c_fetch_grant", {inst_req_ready, mem_req_ready}, 2'b10);
      tick;
      inst_req_valid = 1'b0;
      check("c_fetch_second", {m_req_valid, m_addr}, {1'b1, 32'h40});
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      m_rvalid = 1'b1;
      m_rdata = 32'h11111111;
      tick;
      m_rvalid = 1'b0;
      check("c_fetch_resp", {inst_valid, rdata_valid, inst_data}, {2'b10, 32'h11111111});
      check("c_cnt_once", arb_conflict_cnt, 1);
      inst_ready = 1'b1;
      tick;
      inst_ready = 1'b0;
      // load with core back-pressure
      mem_read = 1'b1;
      mem_addr = 32'h300;
      tick;
      mem_read = 1'b0;
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      m_rvalid = 1'b1;
      m_rdata = 32'hCAFEF00D;
      tick;
      m_rdata = 32'h12345678;
      inst_req_valid = 1'b1;
      inst_addr = 32'h700;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("b_hold%0d", i), {rdata_valid, rdata, m_req_valid, m_rready, inst_req_ready}, {1'b1, 32'hCAFEF00D, 3'b000});
         tick;
      end
      rdata_ready = 1'b1;
      inst_req_valid = 1'b0;
      m_rvalid = 1'b0;
      tick;
      rdata_ready = 1'b0;
      check("b_done", {rdata_valid, m_req_valid}, 0);
      // reset while waiting for read data
      inst_req_valid = 1'b1;
      inst_addr = 32'h500;
      tick;
      inst_req_valid = 1'b0;
      m_req_ready = 1'b1;
      tick;
      m_req_ready = 1'b0;
      check("r_in_wait", {m_rready, arb_conflict_cnt}, {1'b1, 32'd1});
      rst = 1'b0;
      #1;
      check("r_async", {m_rready, m_req_valid, inst_valid, rdata_valid, inst_req_ready, mem_req_ready, m_we}, 0);
      check("r_clear", {m_addr, arb_conflict_cnt}, 0);
      tick;
      rst = 1'b1;
      m_rvalid = 1'b1;
      m_rdata = 32'hBADBAD00;
      #1;
      check("r_no_rready", m_rready, 0);
      tick;
      check("r_late_rvalid", {inst_valid, rdata_valid, m_req_valid}, 0);
      m_rvalid = 1'b0;
      tick;
      check("r_still_idle", {inst_valid, rdata_valid, inst_data}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
